// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and execute-unit FSM states.
// The code enum is common to the decoder and both ALU flavours.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLT  = 4'b0101,
        ALU_PASS = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SLL  = 4'b1010,
        ALU_XOR  = 4'b1100
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SRL) || (code == ALU_SRA) ||
               (code == ALU_SLL);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU for all non-shift operations.
// Shift codes yield 0 here; unknown codes raise illegal with value 0.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] value,
    output logic             illegal
);

    // Decode the operation and compute its value
    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (alu_ctrl_t'(alu_control))
            ALU_ADD:  value = a + b;
            ALU_SUB:  value = a - b;
            ALU_AND:  value = a & b;
            ALU_OR:   value = a | b;
            ALU_XOR:  value = a ^ b;
            ALU_SLT:  value = {{(WIDTH-1){1'b0}},
                               $signed(a) < $signed(b)};
            ALU_PASS: value = b;
            ALU_SRL,
            ALU_SRA,
            ALU_SLL:  value = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: one-cycle arithmetic/logic, shifts one bit
// per cycle, valid/ready on both sides.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    alu_state_t       state;
    alu_ctrl_t        sh_op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] core_val;
    logic             core_ill;

    assign shamt     = b[SHAMT_W-1:0];
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .value       (core_val),
        .illegal     (core_ill)
    );

    // One-bit step of the shift accumulator
    always_comb begin
        acc_next = acc;
        case (sh_op)
            ALU_SRL: acc_next = {1'b0, acc[WIDTH-1:1]};
            ALU_SRA: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            ALU_SLL: acc_next = {acc[WIDTH-2:0], 1'b0};
            default: acc_next = acc;
        endcase
    end

    // Control FSM with shift counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            sh_op   <= ALU_ADD;
            acc     <= '0;
            count   <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift(alu_control)) begin
                            illegal <= 1'b0;
                            sh_op   <= alu_ctrl_t'(alu_control);
                            if (shamt == '0) begin
                                result <= a;
                                zero   <= (a == '0);
                                state  <= ST_DONE;
                            end else begin
                                acc   <= a;
                                count <= shamt;
                                state <= ST_SHIFT;
                            end
                        end else begin
                            result  <= core_val;
                            zero    <= (core_val == '0);
                            illegal <= core_ill;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc   <= acc_next;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: reference results and latencies are
// queued at issue and compared when out_valid appears.
module tb_seq_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_alu dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t e;
        int   n;
        n     = int'(y[4:0]);
        e.ill = 1'b0;
        e.lat = 1;
        case (c)
            4'b0000: e.res = x + y;
            4'b0001: e.res = x - y;
            4'b0010: e.res = x & y;
            4'b0011: e.res = x | y;
            4'b0101: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0111: e.res = y;
            4'b1000: e.res = x >> n;
            4'b1001: e.res = $signed(x) >>> n;
            4'b1010: e.res = x << n;
            4'b1100: e.res = x ^ y;
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        if ((c == 4'b1000 || c == 4'b1001 || c == 4'b1010) && n != 0)
            e.lat = n + 1;
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Drive one op through the input handshake; returns #1 after accept.
    task automatic send(input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL send_in_ready: got %b want 1", in_ready);
        end
        sb.push_back(model(c, x, y));
        alu_control = c;
        a           = x;
        b           = y;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output bit to);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        to = !out_valid;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        alu_control = 4'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, zero, illegal} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 1000",
                     {in_ready, out_valid, zero, illegal});
        end
        n_cmp++;
        if (result !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        reset = 1'b0;
    endtask

    // Run a table of ops; checks values, latency and the handoff.
    task automatic run_table(input string tag, input logic [3:0] cs[],
                             input logic [31:0] xs[],
                             input logic [31:0] ys[]);
        exp_t e;
        int   cyc;
        bit   to;
        for (int i = 0; i < cs.size(); i++) begin
            send(cs[i], xs[i], ys[i]);
            wait_out(cyc, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin
                n_bad++;
                $display("FAIL %s[%0d]_timeout: no out_valid", tag, i);
            end
            n_cmp++;
            if (cyc != e.lat) begin
                n_bad++;
                $display("FAIL %s[%0d]_latency: got %0d want %0d",
                         tag, i, cyc, e.lat);
            end
            n_cmp++;
            if ({result, zero, illegal} !== {e.res, e.z, e.ill}) begin
                n_bad++;
                $display("FAIL %s[%0d]_result: got %h z%b i%b want %h z%b i%b",
                         tag, i, result, zero, illegal, e.res, e.z, e.ill);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_bad++;
                $display("FAIL %s[%0d]_handoff: got %b want 10",
                         tag, i, {in_ready, out_valid});
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0]  cs[] = '{4'b0000, 4'b0001, 4'b0101, 4'b0101,
                              4'b0010, 4'b0011, 4'b0111, 4'b0100,
                              4'b1111};
        logic [31:0] xs[] = '{32'd5, 32'h1234, 32'hFFFFFFFF, 32'd1,
                              32'hF0F0_1234, 32'h0000_00F0, 32'd9,
                              32'd3, 32'd3};
        logic [31:0] ys[] = '{32'd7, 32'h1234, 32'd1, 32'hFFFFFFFF,
                              32'h0FF0_FF00, 32'h0F00_000F, 32'hDEADB000,
                              32'd4, 32'd4};
        run_table("arith", cs, xs, ys);
    endtask

    task automatic test_shift();
        logic [3:0]  cs[] = '{4'b1001, 4'b1000, 4'b1010, 4'b1010,
                              4'b1001, 4'b1000};
        logic [31:0] xs[] = '{32'h80000000, 32'h80000000, 32'd1,
                              32'h1234_5678, 32'h80000000, 32'hA5A5_0000};
        logic [31:0] ys[] = '{32'd4, 32'd4, 32'd31, 32'd0, 32'd31,
                              32'hFFFF_FF23};
        run_table("shift", cs, xs, ys);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  cs[] = '{4'b0000, 4'b1010, 4'b0001};
        logic [31:0] xs[] = '{32'hFFFFFFFF, 32'h3, 32'd0};
        logic [31:0] ys[] = '{32'd1, 32'd2, 32'd1};
        run_table("b2b", cs, xs, ys);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        bit   to;
        out_ready = 1'b0;
        send(4'b1100, 32'hFF00FF00, 32'h0FF00FF0);
        wait_out(cyc, to);
        e = sb.pop_front();
        n_cmp++;
        if (to || result !== e.res) begin
            n_bad++;
            $display("FAIL bp_result: got %h want %h", result, e.res);
        end
        for (int i = 0; i < 6; i++) begin
            alu_control = 4'b0000;
            a = 32'd1 + 32'(i);
            b = 32'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b10 || result !== e.res) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v%b r%b %h want v1 r0 %h",
                         i, out_valid, in_ready, result, e.res);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release: got %b want 10",
                     {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        bit   to;
        send(4'b1000, 32'hFFFF0000, 32'd10);
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10 || result !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset: got r%b v%b %h want r1 v0 0",
                     in_ready, out_valid, result);
        end
        send(4'b0000, 32'd2, 32'd2);
        wait_out(cyc, to);
        e = sb.pop_front();
        n_cmp++;
        if (to || result !== e.res || cyc != e.lat) begin
            n_bad++;
            $display("FAIL midreset_add: got %h lat %0d want %h lat %0d",
                     result, cyc, e.res, e.lat);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_empty: got %0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execute unit; the consumer of the 4-bit alu_control code produced by ALU_decoder.
- Single-cycle arithmetic and logic ops complete in one registered cycle.
- Shifts are iterative, one bit per cycle, to keep the barrel shifter out of the datapath.
- Sits in the execute stage of the multi-cycle core, between the operand registers and the ALUResult register.
- Uses a valid/ready handshake on both sides so the control FSM can stall on shifts.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH), width of the shift amount and of the shift counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  unit idle; the operation is accepted on an edge where in_valid and in_ready are both high.
- alu_control  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A (SrcA).
- b  in  WIDTH  operand B (SrcB); for shifts, b[SHAMT_W-1:0] is the shift amount.
- out_valid  out  1  result, zero and illegal are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0; used for beq.
- illegal  out  1  unsupported alu_control code was accepted.

Behaviour:
- Encodings:
  - ADD 0000: a+b, modulo 2^WIDTH.
  - SUB 0001: a-b, modulo 2^WIDTH.
  - AND 0010.
  - OR 0011.
  - SLT 0101: signed a<b gives 1, else 0, zero-extended.
  - PASS 0111: result = b.
  - SRL 1000.
  - SRA 1001.
  - SLL 1010.
  - XOR 1100.
  - Any other code is illegal.
- Reset, or reset asserted mid-operation:
  - State goes to IDLE; result=0, zero=0, illegal=0, shift counter=0.
  - out_valid=0, in_ready=1 in the cycle after the reset edge.
  - Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE, on accept edge E0:
  - Non-shift op: result = combinational op value; illegal = 0 (for an illegal code, result=0 and illegal=1). Go to DONE.
  - Shift with amount 0: result = a. Go to DONE.
  - Shift with amount n>0: acc = a, count = n. Go to SHIFT.
- SHIFT:
  - Each edge shifts acc by one bit and decrements count: SRL fills 0; SRA fills acc[WIDTH-1]; SLL fills 0 at the LSB.
  - When count==1 on an edge, the shifted value loads result and the state goes to DONE.
- Latency from the accept edge to out_valid visible:
  - Non-shift op: 1 cycle.
  - Shift by n: n+1 cycles.
  - Maximum: WIDTH cycles (shift by WIDTH-1).
- DONE:
  - result, zero and illegal are held stable while out_ready=0.
  - When out_ready=1 on an edge, go to IDLE.
  - No accept in the same cycle as the handoff: in_ready is 0 in DONE.
- zero is computed from the final result and registered with it. It is valid only while out_valid=1.
- Inputs (alu_control, a, b) are sampled only on the accept edge. Changes during SHIFT or DONE are ignored.
- in_valid while busy has no effect. Upstream holds it until in_ready.

Decomposition:
- alu_pkg holds:
  - typedef enum logic[3:0] alu_ctrl_t with the ten codes above; shared with ALU_decoder to replace its local constants.
  - typedef enum for the FSM states.
- Sub-module alu_comb_core: purely combinational; (alu_control, a, b) in, value and illegal flag out for all non-shift ops. It is reused by the single-cycle core.
- seq_alu owns the FSM, shift accumulator, counter and output registers.

Test Plan:
- ADD a=5, b=7, out_ready=1 -> out_valid one cycle after accept; result=12, zero=0; in_ready high the following cycle.
- SUB a=b=0x1234 -> result=0, zero=1. SLT a=0xFFFFFFFF, b=1 -> result=1; SLT a=1, b=0xFFFFFFFF -> result=0.
- SRA a=0x80000000, b=4 -> out_valid exactly 5 cycles after accept, result=0xF8000000. Also:
  - SRL same operands -> 0x08000000.
  - SLL a=1, b=31 -> 0x80000000 after 32 cycles.
  - SLL by 0 -> result=a after 1 cycle.
- Backpressure: XOR a=0xFF00FF00, b=0x0FF00FF0, out_ready=0 for 6 cycles -> result=0xF0F0F0F0 held, out_valid=1, in_ready=0 throughout. in_valid pulses with different operands during the hold are ignored. Release -> IDLE next cycle.
- Illegal code 0100 -> result=0, illegal=1, out_valid after 1 cycle. PASS b=0xDEADB000 -> result=0xDEADB000, illegal=0.
- Reset asserted in the 3rd cycle of an SRL by 10 -> the next cycle shows in_ready=1, out_valid=0, result=0. A new ADD 2+2 then completes with result=4.
